// File: rtl/cpu_types_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : cpu_types_pkg                                              |
// | Brief   : Shared CPU types: RAM status codes and arbiter FSM states. |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package cpu_types_pkg;

  // Status reported by the RAM model / controller each cycle
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Instruction/data RAM arbiter states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } arb_state_t;

endpackage : cpu_types_pkg
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : ram_arbiter                                                 |
// | Brief  : Arbitrates one shared RAM port between icache and dcache.   |
// |          Data has priority, bounded by a starvation limit for the    |
// |          instruction side; grants abort on a cycle timeout.          |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module ram_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT = 3,
  parameter int TIMEOUT      = 255
) (
  input  logic        CLK,
  input  logic        RST,
  // instruction side
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  // data side
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  // RAM side
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  ramstate_t   ramstate,
  // status
  output logic        err
);

  // Last count value before the abort fires: the grant is dropped on the
  // TIMEOUT-th consecutive cycle that does not see ACCESS.
  localparam logic [7:0] c_tmo_last  = 8'(TIMEOUT - 1);
  localparam logic [1:0] c_starve_max = 2'(STARVE_LIMIT);

  arb_state_t  r_state;
  logic [1:0]  r_starve_cnt;
  logic [7:0]  r_tmo_cnt;
  logic        r_err;

  arb_state_t  w_next_state;
  logic [1:0]  w_starve_nxt;
  logic [7:0]  w_tmo_nxt;
  logic        w_err_set;
  logic        w_dreq;

  assign w_dreq = dREN | dWEN;
  assign err    = r_err;

  // Read data is forwarded unconditionally; requesters qualify it with wait
  assign iload  = ramload;
  assign dload  = ramload;

  // State, counters and sticky error flag
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= IDLE;
      r_starve_cnt <= 2'd0;
      r_tmo_cnt    <= 8'd0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_starve_cnt <= w_starve_nxt;
      r_tmo_cnt    <= w_tmo_nxt;
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  // Next-state, counter updates and RAM/requester output decode
  always_comb begin
    w_next_state = r_state;
    w_starve_nxt = r_starve_cnt;
    w_tmo_nxt    = r_tmo_cnt;
    w_err_set    = 1'b0;
    iwait        = 1'b1;
    dwait        = 1'b1;
    ramREN       = 1'b0;
    ramWEN       = 1'b0;
    ramaddr      = 32'd0;
    ramstore     = 32'd0;

    case (r_state)
      IDLE: begin
        // Holding the timeout counter at zero here clears it on grant entry
        w_tmo_nxt = 8'd0;
        if (!iREN) begin
          w_starve_nxt = 2'd0;
        end
        if (w_dreq && iREN) begin
          w_next_state = (r_starve_cnt == c_starve_max) ? IGRANT : DGRANT;
        end else if (w_dreq) begin
          w_next_state = DGRANT;
        end else if (iREN) begin
          w_next_state = IGRANT;
        end
      end

      DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        if (!w_dreq) begin
          // Requester withdrew: release the port without acknowledging
          w_next_state = IDLE;
        end else if (ramstate == ACCESS) begin
          dwait        = 1'b0;
          w_next_state = IDLE;
          if (iREN && (r_starve_cnt != c_starve_max)) begin
            w_starve_nxt = r_starve_cnt + 2'd1;
          end
        end else begin
          if (ramstate == ERROR) begin
            w_err_set = 1'b1;
          end
          if (r_tmo_cnt == c_tmo_last) begin
            w_err_set    = 1'b1;
            w_next_state = IDLE;
          end else begin
            w_tmo_nxt = r_tmo_cnt + 8'd1;
          end
        end
      end

      IGRANT: begin
        ramaddr = iaddr;
        ramREN  = 1'b1;
        if (!iREN) begin
          w_next_state = IDLE;
        end else if (ramstate == ACCESS) begin
          iwait        = 1'b0;
          w_next_state = IDLE;
          w_starve_nxt = 2'd0;
        end else begin
          if (ramstate == ERROR) begin
            w_err_set = 1'b1;
          end
          if (r_tmo_cnt == c_tmo_last) begin
            w_err_set    = 1'b1;
            w_next_state = IDLE;
          end else begin
            w_tmo_nxt = r_tmo_cnt + 8'd1;
          end
        end
      end

      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

endmodule : ram_arbiter
`default_nettype wire
